// File: rtl/add3_stim_gen_if.sv
// Handshake and vector bus between the stimulus generator and its controller/adder side.
// The generator uses the master modport; the controller and monitors use the slave modport.
interface add3_stim_gen_if;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [3:0] loops;
  logic       I0;
  logic       I1;
  logic       I2;
  logic [2:0] vec_idx;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (
    input  start, abort, mode, loops,
    output I0, I1, I2, vec_idx, valid, busy, done
  );

  modport slave (
    output start, abort, mode, loops,
    input  I0, I1, I2, vec_idx, valid, busy, done
  );
endinterface

// File: rtl/add3_stim_gen.sv
// Sweeps all eight 3-bit vectors into the 3-input adder in a selectable order,
// holding each for DWELL cycles, for a latched number of passes (0 = free-run).
module add3_stim_gen #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  add3_stim_gen_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [3:0]       pass_q, pass_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       loops_q, loops_d;

  logic [2:0]       vec;
  logic [3:0]       pass_inc;

  assign pass_inc = pass_q + 4'd1;

  // Vector is a pure function of the latched order and the position in the pass.
  always_comb begin
    case (mode_q)
      2'b01:   vec = 3'd7 - idx_q;
      2'b10:   vec = idx_q ^ (idx_q >> 1);
      default: vec = idx_q;
    endcase
  end

  // NOTE: every signal driven here gets its default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_d     = dwell_q;
    pass_d      = pass_q;
    mode_d      = mode_q;
    loops_d     = loops_q;
    bus.I0      = 1'b0;
    bus.I1      = 1'b0;
    bus.I2      = 1'b0;
    bus.vec_idx = 3'd0;
    bus.valid   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_RUN;
          mode_d  = bus.mode;
          loops_d = bus.loops;
          idx_d   = 3'd0;
          dwell_d = '0;
          pass_d  = 4'd0;
        end
      end

      S_RUN: begin
        {bus.I2, bus.I1, bus.I0} = vec;
        bus.vec_idx = idx_q;
        bus.valid   = 1'b1;
        bus.busy    = 1'b1;
        // Abort wins over the end-of-sweep boundary, so done never fires on an aborted sweep.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (idx_q == 3'd7) begin
            if (loops_q != 4'd0 && pass_inc == loops_q) begin
              state_d = S_DONE;
            end else begin
              idx_d  = 3'd0;
              pass_d = pass_inc;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      dwell_q <= '0;
      pass_q  <= 4'd0;
      mode_q  <= 2'd0;
      loops_q <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      pass_q  <= pass_d;
      mode_q  <= mode_d;
      loops_q <= loops_d;
    end
  end

endmodule

// File: tb/tb_add3_stim_gen.sv
// Directed bench for add3_stim_gen: every output is compared each cycle against
// hand-written vector tables and the DWELL-derived schedule.
module tb_add3_stim_gen;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  add3_stim_gen_if bus ();

  add3_stim_gen #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] seq_up   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] seq_down [8] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [2:0] seq_gray [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  // {I2,I1,I0, vec_idx, valid, busy, done}
  function automatic logic [8:0] obs();
    return {bus.I2, bus.I1, bus.I0, bus.vec_idx, bus.valid, bus.busy, bus.done};
  endfunction

  // Starts a sweep and checks every RUN cycle, then either the kill aftermath or the done pulse.
  task automatic sweep(input string name, input logic [1:0] m, input logic [3:0] l,
                       input logic [2:0] seq [8], input int run_cycles, input int kill_at,
                       input bit kill_rst, input bit disturb);
    logic [8:0] exp;
    int slot;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.loops = l;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= run_cycles; c++) begin
      slot = ((c - 1) / DWELL) % 8;
      exp  = {seq[slot], 3'(slot), 3'b110};
      n_total++;
      if (obs() !== exp) $display("FAIL %s run cycle %0d: got %b expected %b", name, c, obs(), exp);
      else n_pass++;
      if (disturb && c == 10) bus.start = 1'b1;
      if (disturb && c == 11) begin bus.start = 1'b0; bus.mode = ~m; bus.loops = 4'd3; end
      if (c == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else bus.abort = 1'b1;
      end
      @(negedge clk);
    end
    if (kill_at != 0) begin
      n_total++;
      if (obs() !== 9'b0) $display("FAIL %s after kill: got %b expected %b", name, obs(), 9'b0);
      else n_pass++;
      rst = 1'b0; bus.abort = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs() !== 9'b0) $display("FAIL %s idle after kill: got %b expected %b", name, obs(), 9'b0);
      else n_pass++;
    end else if (l != 4'd0) begin
      n_total++;
      if (obs() !== 9'b000_000_001) $display("FAIL %s done pulse: got %b expected %b", name, obs(), 9'b000_000_001);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (obs() !== 9'b0) $display("FAIL %s after done: got %b expected %b", name, obs(), 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.abort = 1'b0; bus.mode = 2'b00; bus.loops = 4'd1;
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if (obs() !== 9'b0) $display("FAIL reset outputs: got %b expected %b", obs(), 9'b0);
    else n_pass++;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs() !== 9'b0) $display("FAIL reset idle: got %b expected %b", obs(), 9'b0);
    else n_pass++;
  endtask

  task automatic test_binary_up();
    sweep("binary_up", 2'b00, 4'd1, seq_up, 8 * DWELL, 0, 1'b0, 1'b0);
  endtask

  task automatic test_binary_down_two_pass();
    sweep("binary_down", 2'b01, 4'd2, seq_down, 16 * DWELL, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gray();
    sweep("gray", 2'b10, 4'd1, seq_gray, 8 * DWELL, 0, 1'b0, 1'b0);
  endtask

  task automatic test_mode11_is_up();
    sweep("mode11", 2'b11, 4'd1, seq_up, 8 * DWELL, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort_free_run();
    int done_seen;
    // vector 5 of pass 3 spans cycles 1+29*DWELL .. 30*DWELL; abort on its second cycle
    sweep("abort_free_run", 2'b00, 4'd0, seq_up, 29 * DWELL + 2, 29 * DWELL + 2, 1'b0, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
      @(negedge clk);
    end
    n_total++;
    if (done_seen != 0) $display("FAIL abort_free_run quiet: got %0d active cycles expected 0", done_seen);
    else n_pass++;
  endtask

  task automatic test_abort_final_dwell();
    sweep("abort_final", 2'b00, 4'd1, seq_up, 8 * DWELL, 8 * DWELL, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_run();
    sweep("start_in_run", 2'b00, 4'd1, seq_up, 8 * DWELL, 0, 1'b0, 1'b1);
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.mode = 2'b00; bus.loops = 4'd1;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || obs() !== 9'b0)
      $display("FAIL start_abort_idle: got %b expected %b", obs(), 9'b0);
    else n_pass++;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    n_total++;
    if (obs() !== 9'b0) $display("FAIL start_abort_idle hold: got %b expected %b", obs(), 9'b0);
    else n_pass++;
  endtask

  task automatic test_rst_mid_sweep();
    // vector 3 spans cycles 3*DWELL+1 .. 4*DWELL; reset on its second cycle
    sweep("rst_mid", 2'b00, 4'd1, seq_up, 3 * DWELL + 2, 3 * DWELL + 2, 1'b1, 1'b0);
    sweep("restart_after_rst", 2'b00, 4'd1, seq_up, 8 * DWELL, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_binary_up();
    test_binary_down_two_pass();
    test_gray();
    test_mode11_is_up();
    test_abort_free_run();
    test_abort_final_dwell();
    test_start_in_run();
    test_start_abort_idle();
    test_rst_mid_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/add3_stim_gen.md
Name: add3_stim_gen

Overview:
- Sequential pattern generator that sits directly upstream of the 3-input adder stage and drives its I0/I1/I2 inputs.
- On a start request it sweeps all eight 3-bit input vectors in a selectable order, holding each for a fixed number of cycles, then pulses done.
- Replaces hand-written delay stimulus with a synthesizable, repeatable driver that also exports a valid strobe and vector index, so downstream checkers can sample the adder output.

Parameters:
- DWELL, 4, clock cycles each vector is held; legal range 1..255.
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  terminate sweep; sampled in RUN (and IDLE, see below).
- mode  input  2  sweep order: 00 binary up, 01 binary down, 10 Gray up, 11 binary up; latched at start.
- loops  input  4  number of full 8-vector passes; 0 = free-run until abort; latched at start.
- I0  output  1  vector bit 0 to adder.
- I1  output  1  vector bit 1 to adder.
- I2  output  1  vector bit 2 to adder (MSB).
- vec_idx  output  3  position within pass, 0..7.
- valid  output  1  high while I2..I0 carry a sweep vector.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final vector of the final pass.

Behaviour:
- Reset: synchronous, active-high. State, counters, I0..I2, vec_idx, valid, busy and done all read 0 on the cycle after rst is sampled high. rst overrides every other input, including mid-sweep.
- FSM states:
  - IDLE: outputs 0. start=1 and abort=0 -> RUN. In the same edge: latch mode and loops, idx=0, dwell=0, pass=0.
  - RUN: valid=1, busy=1. Vector = f(mode_q, idx):
    - binary up: idx
    - binary down: 7-idx
    - Gray: idx ^ (idx>>1)
    - {I2,I1,I0} = vector; vec_idx = idx.
  - DONE: lasts exactly one cycle. done=1; valid, busy, vector and vec_idx are 0. Always -> IDLE.
- RUN counting:
  - dwell increments every cycle. When dwell == DWELL-1: dwell -> 0 and idx advances.
  - When idx == 7 and dwell == DWELL-1: idx wraps to 0 and pass increments.
  - If loops_q != 0 and pass+1 == loops_q at that boundary -> DONE instead of wrapping.
- Latency: the first vector appears the cycle after start is sampled. Vector k of pass p occupies cycles 1+(8p+k)*DWELL .. (8p+k+1)*DWELL after the start edge. done asserts on cycle 8*loops*DWELL+1.
- Each vector is held for exactly DWELL cycles. There are no gaps between vectors or between passes.
- abort=1 in RUN -> IDLE next cycle. No done pulse; outputs go to 0.
- abort takes priority over the end-of-sweep boundary in the same cycle: the block goes to IDLE and done stays 0.
- start and abort both high in IDLE: abort wins, block stays IDLE.
- start in RUN or DONE is ignored; it does not restart the sweep or queue a request.
- Changes to mode or loops during RUN have no effect until the next start.
- Free-run (loops=0): the pass counter may wrap; the sweep continues indefinitely until abort or rst.
- DWELL=1: the vector changes every cycle. The same rules apply.

Test Plan:
- Reset, then start with mode=00, loops=1, DWELL=4 -> {I2,I1,I0} = 0,1,2,...,7, each held 4 cycles with valid=1, busy=1. done is high for exactly 1 cycle at cycle 33 after start; all outputs 0 afterwards.
- mode=01, loops=2 -> sequence 7,6,...,0,7,6,...,0 with no gap at the pass boundary; vec_idx runs 0..7 twice. done at cycle 65.
- mode=10, loops=1 -> sequence 0,1,3,2,6,7,5,4, each held 4 cycles; done at cycle 33.
- loops=0, then abort asserted during vector 5 of pass 3 -> next cycle state is IDLE with outputs 0; done never asserts. Separately, assert abort on the final dwell cycle of loops=1 -> done stays 0.
- start pulsed during RUN, and mode changed mid-sweep -> sweep is unaffected and completes on the original schedule. start and abort together in IDLE -> busy stays 0.
- rst asserted mid-sweep at vector 3 -> the next cycle shows all outputs 0 and state IDLE. A subsequent start begins from vector 0.
